// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 scan counters, syncs and valid on a single clock
// with a pixel-rate enable. hsync/vsync/valid are registered from next-state counters.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       line_end,
    output logic       frame_end
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic          valid_q, valid_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic          h_last, v_last;

    always_comb begin
        div_d     = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
        // gated by rst so the CLK_DIV=1 decode stays low during reset
        pclk_en   = rst & (div_q == DW'(CLK_DIV - 1));
        h_last    = h_q == 10'(H_TOTAL - 1);
        v_last    = v_q == 10'(V_TOTAL - 1);
        h_d       = pclk_en ? (h_last ? '0 : h_q + 10'd1) : h_q;
        v_d       = (pclk_en && h_last) ? (v_last ? '0 : v_q + 10'd1) : v_q;
        hsync_d   = !(h_d >= 10'(H_ACTIVE + H_FP) && h_d < 10'(H_ACTIVE + H_FP + H_SYNC));
        vsync_d   = !(v_d >= 10'(V_ACTIVE + V_FP) && v_d < 10'(V_ACTIVE + V_FP + V_SYNC));
        valid_d   = (h_d < 10'(H_ACTIVE)) && (v_d < 10'(V_ACTIVE));
        line_end  = pclk_en & h_last;
        frame_end = line_end & v_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            valid_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign h_cnt = h_q;
    assign v_cnt = v_q;
    assign valid = valid_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench; expectations come from a closed-form model
// indexed by clock edges since reset release, plus directed window/period checks.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       pclk_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       hsync;
        logic       vsync;
        logic       line_end;
        logic       frame_end;
    } out_t;

    logic clk = 1'b0;
    logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
    wire out_t o0, o1, o2;
    int n_cmp = 0, n_bad = 0;
    int k0 = 0, k1 = 0, k2 = 0;
    out_t sb0[$], sb1[$], sb2[$];

    always #5 clk = ~clk;

    vga_timing_gen u0 (
        .clk(clk), .rst(rst0), .pclk_en(o0.pclk_en), .h_cnt(o0.h), .v_cnt(o0.v),
        .valid(o0.valid), .hsync(o0.hsync), .vsync(o0.vsync),
        .line_end(o0.line_end), .frame_end(o0.frame_end)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u1 (
        .clk(clk), .rst(rst1), .pclk_en(o1.pclk_en), .h_cnt(o1.h), .v_cnt(o1.v),
        .valid(o1.valid), .hsync(o1.hsync), .vsync(o1.vsync),
        .line_end(o1.line_end), .frame_end(o1.frame_end)
    );

    vga_timing_gen #(.CLK_DIV(1)) u2 (
        .clk(clk), .rst(rst2), .pclk_en(o2.pclk_en), .h_cnt(o2.h), .v_cnt(o2.v),
        .valid(o2.valid), .hsync(o2.hsync), .vsync(o2.vsync),
        .line_end(o2.line_end), .frame_end(o2.frame_end)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input out_t obs, input out_t exp);
        check({tag, ".pclk_en"}, 32'(obs.pclk_en), 32'(exp.pclk_en));
        check({tag, ".h"}, 32'(obs.h), 32'(exp.h));
        check({tag, ".v"}, 32'(obs.v), 32'(exp.v));
        check({tag, ".valid"}, 32'(obs.valid), 32'(exp.valid));
        check({tag, ".hsync"}, 32'(obs.hsync), 32'(exp.hsync));
        check({tag, ".vsync"}, 32'(obs.vsync), 32'(exp.vsync));
        check({tag, ".line_end"}, 32'(obs.line_end), 32'(exp.line_end));
        check({tag, ".frame_end"}, 32'(obs.frame_end), 32'(exp.frame_end));
    endtask

    // k = clock edges seen since release; pixel ticks completed = k / cd
    function automatic out_t model(input int k, input bit in_rst, input int cd,
                                   input int ha, input int hfp, input int hs, input int hbp,
                                   input int va, input int vfp, input int vs, input int vbp);
        out_t r;
        int n, ht, vt, h, v;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        r = '0;
        r.hsync = 1'b1;
        r.vsync = 1'b1;
        if (in_rst) return r;
        n = k / cd;
        h = n % ht;
        v = (n / ht) % vt;
        r.h = 10'(h);
        r.v = 10'(v);
        r.pclk_en = (k % cd) == cd - 1;
        r.valid = k > 0 && h < ha && v < va;
        r.hsync = !(h >= ha + hfp && h < ha + hfp + hs);
        r.vsync = !(v >= va + vfp && v < va + vfp + vs);
        r.line_end = r.pclk_en && h == ht - 1;
        r.frame_end = r.line_end && v == vt - 1;
        return r;
    endfunction

    always @(posedge clk) begin
        k0 = rst0 ? k0 + 1 : 0;
        k1 = rst1 ? k1 + 1 : 0;
        k2 = rst2 ? k2 + 1 : 0;
        sb0.push_back(model(k0, !rst0, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        sb1.push_back(model(k1, !rst1, 4, 8, 2, 3, 3, 6, 2, 2, 2));
        sb2.push_back(model(k2, !rst2, 1, 640, 16, 96, 48, 480, 10, 2, 33));
    end

    always @(negedge clk) begin
        if (sb0.size() > 0) check_out("sb0", o0, sb0.pop_front());
        if (sb1.size() > 0) check_out("sb1", o1, sb1.pop_front());
        if (sb2.size() > 0) check_out("sb2", o2, sb2.pop_front());
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, c, vmin, vmax;
        repeat (3) @(negedge clk);
        #1;
        check("rst_h", 32'(o0.h), 0);
        check("rst_v", 32'(o0.v), 0);
        check("rst_valid", 32'(o0.valid), 0);
        check("rst_hsync", 32'(o0.hsync), 1);
        check("rst_vsync", 32'(o0.vsync), 1);
        check("rst_pclk_div1", 32'(o2.pclk_en), 0);
        @(negedge clk);
        #2;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        #1;
        check("rel_pclk_div1", 32'(o2.pclk_en), 1);
        t = 0;
        while (o0.h != 10'd1 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("first_tick_edges", t, 4);
        c = 0;
        do begin @(negedge clk); c++; end while (!o0.pclk_en && c < 20);
        c = 0;
        do begin @(negedge clk); c++; end while (!o0.pclk_en && c < 20);
        check("pclk_period", c, 4);
        c = 0;
        while (o0.valid && c < 5000) begin @(negedge clk); c++; end
        check("valid_fall_h", 32'(o0.h), 640);
        c = 0;
        while (o0.hsync && c < 5000) begin @(negedge clk); c++; end
        check("hsync_fall_h", 32'(o0.h), 656);
        c = 0;
        while (!o0.hsync && c < 1000) begin @(negedge clk); c++; end
        check("hsync_low_clk", c, 384);
        check("hsync_rise_h", 32'(o0.h), 752);
        c = 0;
        while (!o0.line_end && c < 5000) begin @(negedge clk); c++; end
        check("line_end_h", 32'(o0.h), 799);
        @(negedge clk);
        check("line_end_width", 32'(o0.line_end), 0);
        check("wrap_h", 32'(o0.h), 0);
        check("wrap_v", 32'(o0.v), 1);
        check("wrap_valid", 32'(o0.valid), 1);
        c = 0;
        while (!o1.frame_end && c < 2000) begin @(negedge clk); c++; end
        check("frame_end_seen", 32'(o1.frame_end), 1);
        check("frame_end_hv", {o1.h, o1.v}, {10'd15, 10'd11});
        c = 0;
        vmin = 99;
        vmax = -1;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) check("frame_wrap_hv", {o1.h, o1.v}, 0);
            if (!o1.vsync && int'(o1.v) < vmin) vmin = int'(o1.v);
            if (!o1.vsync && int'(o1.v) > vmax) vmax = int'(o1.v);
        end while (!o1.frame_end && c < 2000);
        check("frame_period", c, 768);
        check("vsync_first_v", vmin, 8);
        check("vsync_last_v", vmax, 9);
        c = 0;
        while (!(o1.h == 10'd5 && o1.v == 10'd3) && c < 2000) begin @(negedge clk); c++; end
        check("midrst_reach", {o1.h, o1.v}, {10'd5, 10'd3});
        #3;
        rst1 = 1'b0;
        #1;
        check_out("midrst_clear", o1, model(0, 1'b1, 4, 8, 2, 3, 3, 6, 2, 2, 2));
        repeat (3) @(negedge clk);
        #2;
        rst1 = 1'b1;
        t = 0;
        while (o1.h != 10'd1 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("midrst_first_tick", t, 4);
        check("midrst_v", 32'(o1.v), 0);
        c = 0;
        while (!o2.line_end && c < 2000) begin @(negedge clk); c++; end
        c = 0;
        do begin @(negedge clk); c++; end while (!o2.line_end && c < 2000);
        check("div1_line_clk", c, 800);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
